// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute sequencer driving every DataPath strobe.
// Define INSTR_COUNT_EN to add the instr_count retired-instruction counter output.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD_OP   = 5'b00011,
  parameter int         MEM_WAIT_MAX = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [4:0]  ir_opcode,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal_op,
`ifdef INSTR_COUNT_EN
  output logic [31:0] instr_count,
`endif
  output logic        mem_fault
);

  // state | meaning
  // RST   | held in reset; leaves on the first edge with clear high
  // T0-T2 | fetch: MAR<=PC, PC++, memory read, IR<=MDR
  // T3-T7 | execute steps of the decoded opcode
  // HALT  | absorbing stop after halt or a memory-wait timeout
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX - 1);

  state_t         state;
  logic [CW-1:0]  wait_count;
  logic           is_ld, is_ldi, is_st, is_alu, is_addi, is_nop, is_halt;
  logic           is_mem, has_exec, in_wait, stall;

  assign is_ld    = (ir_opcode == OP_LD);
  assign is_ldi   = (ir_opcode == OP_LDI);
  assign is_st    = (ir_opcode == OP_ST);
  assign is_alu   = (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB) ||
                    (ir_opcode == OP_AND) || (ir_opcode == OP_OR);
  assign is_addi  = (ir_opcode == OP_ADDI);
  assign is_nop   = (ir_opcode == OP_NOP);
  assign is_halt  = (ir_opcode == OP_HALT);
  assign is_mem   = is_ld || is_st;
  assign has_exec = is_mem || is_ldi || is_alu || is_addi;

  // Only these three states wait on mem_ready; elsewhere it is ignored.
  assign in_wait = (state == T1) || ((state == T6) && is_ld) || ((state == T7) && is_st);
  assign stall   = in_wait && !mem_ready;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= RST;
      wait_count <= '0;
      mem_fault  <= 1'b0;
    end else if (stall) begin
      if (wait_count == WAIT_LIMIT) begin
        state      <= HALT;
        mem_fault  <= 1'b1;
        wait_count <= '0;
      end else begin
        wait_count <= wait_count + 1'b1;
      end
    end else begin
      wait_count <= '0;
      unique case (state)
        RST:  state <= T0;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_halt)       state <= HALT;
          else if (has_exec) state <= T4;
          else               state <= T0;
        end
        T4:   state <= T5;
        T5:   state <= is_mem ? T6 : T0;
        T6:   state <= T7;
        T7:   state <= T0;
        HALT: state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Yin = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    Cout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    alu_op = '0; halted = 1'b0; illegal_op = 1'b0;
    unique case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_mem || is_ldi) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu || is_addi) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (!is_nop && !is_halt) begin
          illegal_op = 1'b1;
        end
      end
      T4: begin
        ZLowIn = 1'b1;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; alu_op = ir_opcode;
        end else begin
          Cout = 1'b1; alu_op = ALU_ADD_OP;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_mem) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      T6: begin
        MDRin = 1'b1;
        if (is_st) begin Gra = 1'b1; Rout = 1'b1; end
        else Read = 1'b1;
      end
      T7: begin
        if (is_st) Write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic retire;

  // An instruction retires on its final step back into T0; halt and timeouts never retire.
  assign retire = ((state == T3) && !is_halt && !has_exec) ||
                  ((state == T5) && !is_mem) ||
                  ((state == T7) && !stall);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed, self-checking bench for control_sequencer (MEM_WAIT_MAX=4).
module tb_control_sequencer;
  logic        clock = 1'b0;
  logic        clear;
  logic [4:0]  ir_opcode;
  logic        mem_ready;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, ZLowIn, ZHighIn, Zlowout, Zhighout;
  logic Cout, HIin, LOin;
  logic [4:0]  alu_op;
  logic        halted, illegal_op, mem_fault;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
  logic [31:0] exp_count;
`endif
  int checks = 0;
  int failures = 0;
  logic [22:0] strobes;

  localparam logic [22:0] B_PCOUT = 23'd1 << 22, B_PCIN = 23'd1 << 21, B_INCPC = 23'd1 << 20;
  localparam logic [22:0] B_MARIN = 23'd1 << 19, B_MDRIN = 23'd1 << 18, B_MDROUT = 23'd1 << 17;
  localparam logic [22:0] B_IRIN = 23'd1 << 16, B_READ = 23'd1 << 15, B_WRITE = 23'd1 << 14;
  localparam logic [22:0] B_GRA = 23'd1 << 13, B_GRB = 23'd1 << 12, B_GRC = 23'd1 << 11;
  localparam logic [22:0] B_RIN = 23'd1 << 10, B_ROUT = 23'd1 << 9, B_BAOUT = 23'd1 << 8;
  localparam logic [22:0] B_YIN = 23'd1 << 7, B_ZLOWIN = 23'd1 << 6, B_ZLOWOUT = 23'd1 << 4;
  localparam logic [22:0] B_COUT = 23'd1 << 2;
  localparam logic [22:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [22:0] F1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [22:0] F2 = B_MDROUT | B_IRIN;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR = 5'b00110, OP_ADDI = 5'b01100, OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  assign strobes = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write,
                    Gra, Grb, Grc, Rin, Rout, BAout, Yin, ZLowIn, ZHighIn, Zlowout,
                    Zhighout, Cout, HIin, LOin};

  always #5 clock = ~clock;

  control_sequencer #(.ALU_ADD_OP(5'b00011), .MEM_WAIT_MAX(4)) dut (
    .clock(clock), .clear(clear), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op),
`ifdef INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .mem_fault(mem_fault)
  );

  // Leaves the DUT in T0, observed at a falling edge.
  task automatic do_reset();
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
`ifdef INSTR_COUNT_EN
    exp_count = 0;
`endif
  endtask

  task automatic test_reset();
    clear = 1'b1; mem_ready = 1'b1; ir_opcode = OP_LD;
`ifdef INSTR_COUNT_EN
    exp_count = 0;
`endif
    #1 clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (strobes !== 23'd0) begin failures++; $display("FAIL reset_strobes got=%h want=0", strobes); end
    checks++;
    if ({alu_op, halted, illegal_op, mem_fault} !== 8'd0) begin
      failures++; $display("FAIL reset_misc got=%b want=0", {alu_op, halted, illegal_op, mem_fault});
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", instr_count); end
`endif
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (strobes !== F0) begin failures++; $display("FAIL first_t0 got=%h want=%h", strobes, F0); end
  endtask

  task automatic test_ld();
    logic [22:0] es [0:8];
    logic [4:0]  ea;
    es[0] = F0; es[1] = F1; es[2] = F2; es[3] = B_GRB | B_BAOUT | B_YIN;
    es[4] = B_COUT | B_ZLOWIN; es[5] = B_ZLOWOUT | B_MARIN; es[6] = B_READ | B_MDRIN;
    es[7] = B_MDROUT | B_GRA | B_RIN; es[8] = F0;
    ir_opcode = OP_LD; mem_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      ea = (c == 4) ? 5'b00011 : 5'b00000;
      checks++;
      if (strobes !== es[c]) begin failures++; $display("FAIL ld_strobes c=%0d got=%h want=%h", c, strobes, es[c]); end
      checks++;
      if (alu_op !== ea) begin failures++; $display("FAIL ld_alu_op c=%0d got=%b want=%b", c, alu_op, ea); end
      if (c < 8) @(negedge clock);
    end
`ifdef INSTR_COUNT_EN
    exp_count++;
    checks++;
    if (instr_count !== exp_count) begin failures++; $display("FAIL ld_count got=%0d want=%0d", instr_count, exp_count); end
`endif
  endtask

  task automatic test_st_stall();
    logic [22:0] es [0:11];
    es[0] = F0; es[1] = F1; es[2] = F2; es[3] = B_GRB | B_BAOUT | B_YIN;
    es[4] = B_COUT | B_ZLOWIN; es[5] = B_ZLOWOUT | B_MARIN; es[6] = B_GRA | B_ROUT | B_MDRIN;
    es[7] = B_WRITE; es[8] = B_WRITE; es[9] = B_WRITE; es[10] = B_WRITE; es[11] = F0;
    ir_opcode = OP_ST; mem_ready = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      checks++;
      if (strobes !== es[c]) begin failures++; $display("FAIL st_strobes c=%0d got=%h want=%h", c, strobes, es[c]); end
      // low through T5/T6 (not wait states) and the first three T7 cycles
      mem_ready = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      if (c < 11) @(negedge clock);
    end
    checks++;
    if (mem_fault !== 1'b0) begin failures++; $display("FAIL st_no_fault got=%b want=0", mem_fault); end
`ifdef INSTR_COUNT_EN
    exp_count++;
    checks++;
    if (instr_count !== exp_count) begin failures++; $display("FAIL st_count got=%0d want=%0d", instr_count, exp_count); end
`endif
  endtask

  task automatic test_six_cycle();
    logic [4:0]  ops [0:5];
    logic [22:0] es;
    logic [4:0]  ea;
    ops[0] = OP_LDI; ops[1] = OP_ADD; ops[2] = OP_SUB;
    ops[3] = OP_AND; ops[4] = OP_OR; ops[5] = OP_ADDI;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ir_opcode = ops[i];
      for (int c = 0; c <= 5; c++) begin
        ea = 5'b00000;
        case (c)
          0: es = F0;
          1: es = F1;
          2: es = F2;
          3: es = (ops[i] == OP_LDI) ? (B_GRB | B_BAOUT | B_YIN) : (B_GRB | B_ROUT | B_YIN);
          4: begin
            if (ops[i] == OP_LDI || ops[i] == OP_ADDI) begin es = B_COUT | B_ZLOWIN; ea = 5'b00011; end
            else begin es = B_GRC | B_ROUT | B_ZLOWIN; ea = ops[i]; end
          end
          default: es = B_ZLOWOUT | B_GRA | B_RIN;
        endcase
        checks++;
        if (strobes !== es) begin failures++; $display("FAIL op%b_strobes c=%0d got=%h want=%h", ops[i], c, strobes, es); end
        checks++;
        if (alu_op !== ea) begin failures++; $display("FAIL op%b_alu_op c=%0d got=%b want=%b", ops[i], c, alu_op, ea); end
        @(negedge clock);
      end
`ifdef INSTR_COUNT_EN
      exp_count++;
`endif
    end
    checks++;
    if (strobes !== F0) begin failures++; $display("FAIL six_cycle_end got=%h want=%h", strobes, F0); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== exp_count) begin failures++; $display("FAIL six_count got=%0d want=%0d", instr_count, exp_count); end
`endif
  endtask

  task automatic test_nop_illegal();
    logic [4:0]  ops [0:2];
    logic [22:0] es;
    logic        ei;
    ops[0] = OP_NOP; ops[1] = 5'b11111; ops[2] = 5'b10000;
    for (int i = 0; i < 3; i++) begin
      ir_opcode = ops[i];
      for (int c = 0; c <= 3; c++) begin
        es = (c == 0) ? F0 : (c == 1) ? F1 : (c == 2) ? F2 : 23'd0;
        ei = (c == 3) && (ops[i] != OP_NOP);
        checks++;
        if (strobes !== es) begin failures++; $display("FAIL nopill%b_strobes c=%0d got=%h want=%h", ops[i], c, strobes, es); end
        checks++;
        if (illegal_op !== ei) begin failures++; $display("FAIL nopill%b_illegal c=%0d got=%b want=%b", ops[i], c, illegal_op, ei); end
        @(negedge clock);
      end
`ifdef INSTR_COUNT_EN
      exp_count++;
`endif
    end
    checks++;
    if ({strobes, illegal_op} !== {F0, 1'b0}) begin
      failures++; $display("FAIL nopill_end got=%h/%b want=%h/0", strobes, illegal_op, F0);
    end
  endtask

  task automatic test_halt();
    ir_opcode = OP_HALT;
    repeat (3) @(negedge clock);
    checks++;
    if ({strobes, halted, illegal_op} !== 25'd0) begin
      failures++; $display("FAIL halt_t3 got=%h/%b/%b want=0", strobes, halted, illegal_op);
    end
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      @(negedge clock);
      checks++;
      if ({strobes, alu_op, halted} !== 29'd1) begin
        failures++; $display("FAIL halt_hold c=%0d got=%h/%b/%b want=0/0/1", c, strobes, alu_op, halted);
      end
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== exp_count) begin failures++; $display("FAIL halt_count got=%0d want=%0d", instr_count, exp_count); end
`endif
  endtask

  task automatic test_mem_timeout();
    do_reset();
    ir_opcode = OP_NOP;
    for (int c = 0; c <= 4; c++) begin
      mem_ready = 1'b0;
      @(negedge clock);
      if (c < 4) begin
        checks++;
        if ({strobes, mem_fault} !== {F1, 1'b0}) begin
          failures++; $display("FAIL timeout_t1 c=%0d got=%h/%b want=%h/0", c, strobes, mem_fault, F1);
        end
      end
    end
    checks++;
    if ({strobes, halted, mem_fault} !== {23'd0, 2'b11}) begin
      failures++; $display("FAIL timeout_halt got=%h/%b/%b want=0/1/1", strobes, halted, mem_fault);
    end
    mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({halted, mem_fault} !== 2'b11) begin failures++; $display("FAIL timeout_sticky got=%b want=11", {halted, mem_fault}); end
    do_reset();
    checks++;
    if ({strobes, mem_fault} !== {F0, 1'b0}) begin
      failures++; $display("FAIL timeout_reset got=%h/%b want=%h/0", strobes, mem_fault, F0);
    end
    for (int c = 0; c <= 4; c++) begin
      mem_ready = (c == 4) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (c < 4) begin
        checks++;
        if (strobes !== F1) begin failures++; $display("FAIL edge_t1 c=%0d got=%h want=%h", c, strobes, F1); end
      end
    end
    checks++;
    if ({strobes, mem_fault} !== {F2, 1'b0}) begin
      failures++; $display("FAIL edge_ready_wins got=%h/%b want=%h/0", strobes, mem_fault, F2);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (strobes !== F0) begin failures++; $display("FAIL edge_next_t0 got=%h want=%h", strobes, F0); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd1) begin failures++; $display("FAIL edge_count got=%0d want=1", instr_count); end
`endif
  endtask

  task automatic test_clear_midway();
    do_reset();
    ir_opcode = OP_LD; mem_ready = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (strobes !== (B_READ | B_MDRIN)) begin failures++; $display("FAIL mid_t6 got=%h want=%h", strobes, B_READ | B_MDRIN); end
    clear = 1'b0;
    #1;
    checks++;
    if ({strobes, alu_op} !== 28'd0) begin failures++; $display("FAIL mid_async_drop got=%h want=0", strobes); end
    @(negedge clock);
    checks++;
    if (strobes !== 23'd0) begin failures++; $display("FAIL mid_held got=%h want=0", strobes); end
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (strobes !== F0) begin failures++; $display("FAIL mid_release_t0 got=%h want=%h", strobes, F0); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d want=0", instr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_ld();
    test_st_stall();
    test_six_cycle();
    test_nop_illegal();
    test_halt();
    test_mem_timeout();
    test_clear_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
